// File: rtl/deco_frame_tx_if.sv
// Handshake and data bus bundle between frame source, decoder core and deco_frame_tx.
interface deco_frame_tx_if #(
    parameter int unsigned WORD_W    = 21,
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned RES_W     = 5,
    parameter int unsigned IDX_W     = 16
);
    localparam int unsigned FRAME_W = WORD_W * NUM_WORDS;

    // upstream frame handshake
    logic               frame_valid_i;
    logic [FRAME_W-1:0] frame_i;
    logic               frame_ready_o;
    // decoder side
    logic               start_o;
    logic [WORD_W-1:0]  data_o;
    logic               done_i;
    logic [RES_W-1:0]   result_i;
    // upstream result handshake
    logic               res_valid_o;
    logic               res_ready_i;
    logic [RES_W-1:0]   res_data_o;
    logic [IDX_W-1:0]   res_idx_o;
    logic               timeout_o;
    logic               proto_err_o;

    // view seen by deco_frame_tx
    modport slave (
        input  frame_valid_i, frame_i, done_i, result_i, res_ready_i,
        output frame_ready_o, start_o, data_o, res_valid_o, res_data_o,
               res_idx_o, timeout_o, proto_err_o
    );

    // view seen by the surrounding environment
    modport master (
        output frame_valid_i, frame_i, done_i, result_i, res_ready_i,
        input  frame_ready_o, start_o, data_o, res_valid_o, res_data_o,
               res_idx_o, timeout_o, proto_err_o
    );
endinterface

// File: rtl/deco_frame_tx.sv
// Turbo decoder transmit front end: serialises one frame into start/data beats,
// waits for the decoder result (or a timeout) and returns it upstream with an index.
module deco_frame_tx #(
    parameter int unsigned WORD_W    = 21,
    parameter int unsigned NUM_WORDS = 4,
    parameter int unsigned RES_W     = 5,
    parameter int unsigned TIMEOUT   = 4096,
    parameter int unsigned IDX_W     = 16
) (
    input  logic            clk_p_i,
    input  logic            reset_p_i,
    deco_frame_tx_if.slave  bus
);
    localparam int unsigned FRAME_W = WORD_W * NUM_WORDS;
    localparam int unsigned BEAT_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned WAIT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_WORDS - 1);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, SEND, HOLD, WAIT, OUT} state_t;

    state_t              state_q, state_d;
    logic [FRAME_W-1:0]  shift_q, shift_d;     // words still to be sent, next word in LSBs
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                ready_q, ready_d;
    logic                start_q, start_d;
    logic [WORD_W-1:0]   data_q, data_d;
    logic                valid_q, valid_d;
    logic [RES_W-1:0]    res_q, res_d;
    logic [IDX_W-1:0]    res_idx_q, res_idx_d;
    logic                timeout_q, timeout_d;
    logic                perr_q, perr_d;

    // State and registered outputs
    always_ff @(posedge clk_p_i or posedge reset_p_i) begin
        if (reset_p_i) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            beat_q    <= '0;
            wait_q    <= '0;
            idx_q     <= '0;
            ready_q   <= 1'b0;
            start_q   <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            res_q     <= '0;
            res_idx_q <= '0;
            timeout_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            beat_q    <= beat_d;
            wait_q    <= wait_d;
            idx_q     <= idx_d;
            ready_q   <= ready_d;
            start_q   <= start_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            res_q     <= res_d;
            res_idx_q <= res_idx_d;
            timeout_q <= timeout_d;
            perr_q    <= perr_d;
        end
    end

    // Next-state and next-output values; outputs reflect the state being entered
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        beat_d    = beat_q;
        wait_d    = wait_q;
        idx_d     = idx_q;
        ready_d   = ready_q;
        start_d   = start_q;
        data_d    = data_q;
        valid_d   = valid_q;
        res_d     = res_q;
        res_idx_d = res_idx_q;
        timeout_d = timeout_q;
        perr_d    = perr_q;

        // done outside WAIT is a decoder protocol violation, remembered until reset
        if (bus.done_i && (state_q != WAIT)) begin
            perr_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (bus.frame_valid_i && ready_q) begin
                    ready_d = 1'b0;
                    start_d = 1'b1;
                    data_d  = bus.frame_i[WORD_W-1:0];
                    shift_d = {WORD_W'(0), bus.frame_i[FRAME_W-1:WORD_W]};
                    beat_d  = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (beat_q == LAST_BEAT) begin
                    // last word stays on the bus for the decoder's extra start cycle
                    state_d = HOLD;
                end else begin
                    data_d  = shift_q[WORD_W-1:0];
                    shift_d = shift_q >> WORD_W;
                    beat_d  = beat_q + BEAT_W'(1);
                end
            end
            HOLD: begin
                start_d = 1'b0;
                wait_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.done_i) begin
                    res_d     = bus.result_i;
                    timeout_d = 1'b0;
                    valid_d   = 1'b1;
                    res_idx_d = idx_q;
                    state_d   = OUT;
                end else if (wait_q == LAST_WAIT) begin
                    res_d     = '0;
                    timeout_d = 1'b1;
                    valid_d   = 1'b1;
                    res_idx_d = idx_q;
                    state_d   = OUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            OUT: begin
                if (bus.res_ready_i) begin
                    valid_d = 1'b0;
                    idx_d   = idx_q + IDX_W'(1);
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.frame_ready_o = ready_q;
    assign bus.start_o       = start_q;
    assign bus.data_o        = data_q;
    assign bus.res_valid_o   = valid_q;
    assign bus.res_data_o    = res_q;
    assign bus.res_idx_o     = res_idx_q;
    assign bus.timeout_o     = timeout_q;
    assign bus.proto_err_o   = perr_q;
endmodule
